gray_counter_param: RTL and testbench
=====================================

Name: gray_counter_param

Overview:
- Parametrised up/down Gray-code counter; successor to the fixed 4-bit free-running Gray counter.
- Adds configurable width, count enable, direction control, synchronous parallel load, selectable wrap/saturate mode and terminal-count/saturation flags.
- Exposes the Gray-coded count for clock-domain crossing and a binary mirror for scoreboarding.
- Sits as a standalone leaf, e.g. as the pointer generator of an async FIFO or a position encoder stimulus source.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- SATURATE, 0: 0 = wrap modulo 2^WIDTH; 1 = hold at endpoint (max when counting up, 0 when counting down).
- RESET_VAL, 0: binary value loaded on reset; must be less than 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to clk.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  binary value to load.
- gray_count  output  WIDTH  registered Gray-coded count, equal to bin ^ (bin >> 1).
- bin_count_out  output  WIDTH  registered binary count.
- tc  output  1  registered one-cycle pulse marking a wrap.
- sat  output  1  registered one-cycle pulse marking a blocked step.

Behaviour:
- Reset (rst=0, asynchronous):
  - bin_count_out = RESET_VAL and gray_count = RESET_VAL ^ (RESET_VAL >> 1).
  - tc = 0 and sat = 0.
  - Holds for as long as rst=0. All inputs are ignored, including a load or en arriving in the same cycle.
- Single binary state register: gray_count is registered from the same next-state value as the binary register, so both outputs update on the same clk edge. There is no cycle skew between them.
- Latency: one cycle. The input condition at edge N is visible on the outputs after edge N.
- Priority per rising edge, out of reset:
  1. load=1: bin <= load_val; tc <= 0; sat <= 0. en and up_dn are ignored.
  2. Else en=1, up_dn=1:
     - At bin = 2^WIDTH-1 with SATURATE=0: bin <= 0; tc <= 1.
     - At bin = 2^WIDTH-1 with SATURATE=1: bin holds; sat <= 1.
     - Otherwise: bin <= bin+1.
  3. Else en=1, up_dn=0:
     - At bin = 0 with SATURATE=0: bin <= 2^WIDTH-1; tc <= 1.
     - At bin = 0 with SATURATE=1: bin holds; sat <= 1.
     - Otherwise: bin <= bin-1.
  4. Else (en=0): bin holds.
- tc and sat default to 0 on every edge that does not set them; they are never high for two consecutive cycles unless the triggering condition repeats.
- Arithmetic is unsigned modulo 2^WIDTH, with no overflow bit.
- tc is never asserted when SATURATE=1; sat is never asserted when SATURATE=0.
- Gray invariant: on every normal count step (not load, not reset), gray_count changes in exactly one bit, or in zero bits on a hold or saturation. A load may change any number of bits.
- Direction reversal takes effect on the same edge, with no dead cycle.
- Reset asserted mid-count: outputs go to reset values without waiting for clk. The first count after release starts from RESET_VAL.

Test Plan:
- Reset/reset value: WIDTH=4, RESET_VAL=5, hold rst=0 with en=1 and load=1 -> bin=5, gray=4'b0111, tc=0, sat=0; release, en=0 for 3 cycles -> values unchanged.
- Up-count wrap: WIDTH=4, SATURATE=0, start at 0, en=1, up_dn=1 for 16 cycles -> gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. tc pulses exactly once, on the 15->0 step. Bench checks a one-bit Hamming change every step.
- Down-count and reversal: load 2, then up_dn=0 for 3 cycles -> bin 1,0,15 with tc on the 0->15 step; then up_dn=1 -> bin 0 on the next edge with tc pulsed.
- Saturation: WIDTH=4, SATURATE=1, load 14, en=1 up for 3 cycles -> bin 15,15,15 and sat pulses on the 2nd and 3rd edges; tc stays 0. Then down for 1 cycle -> bin 14, sat=0.
- Load priority: at bin=7 with en=1, up_dn=1, load=1, load_val=3 -> bin=3, gray=4'b0010, no tc. Load of 15 followed by en up -> wrap to 0 with tc.
- Async reset mid-operation: WIDTH=8, counting up at bin=200; drop rst between clock edges -> outputs go to RESET_VAL immediately, before the next edge. Release rst with en=1 -> bin=RESET_VAL+1 after the first post-release edge.

Source files
------------

// File: rtl/gray_counter_param.sv
// gray_counter_param: up/down Gray-code counter with load, wrap/saturate mode and tc/sat pulses.
module gray_counter_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_count,
  output logic [WIDTH-1:0] bin_count_out,
  output logic             tc,
  output logic             sat
);
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam bit SAT_MODE = SATURATE != 0;
  logic [WIDTH-1:0] bin_nxt, step;
  logic             at_end;
  // Wrap falls out of modulo arithmetic; saturation just suppresses the step.
  always_comb begin
    at_end  = en && (up_dn ? &bin_count_out : ~|bin_count_out);
    step    = up_dn ? bin_count_out + 1'b1 : bin_count_out - 1'b1;
    bin_nxt = load ? load_val : (!en || (at_end && SAT_MODE)) ? bin_count_out : step;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_count_out <= RST_BIN;
      gray_count    <= RST_GRAY;
      tc            <= 1'b0;
      sat           <= 1'b0;
    end else begin
      bin_count_out <= bin_nxt;
      gray_count    <= bin_nxt ^ (bin_nxt >> 1);
      tc            <= !load && at_end && !SAT_MODE;
      sat           <= !load && at_end && SAT_MODE;
    end
  end
endmodule

// File: tb/tb_gray_counter_param.sv
// tb_gray_counter_param: directed checks on wrap (W4, RV5), saturate (W4) and wide (W8, RV10) instances.
module tb_gray_counter_param;
  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] lv4;
  logic [7:0] lv8;
  logic [3:0] a_gray, a_bin, b_gray, b_bin;
  logic [7:0] c_gray, c_bin;
  logic       a_tc, a_sat, b_tc, b_sat, c_tc, c_sat;
  int errors = 0;
  int checks = 0;
  logic [3:0] gray_seq [0:16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
  logic [3:0] prev;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_VAL(5)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .gray_count(a_gray), .bin_count_out(a_bin), .tc(a_tc), .sat(a_sat));
  gray_counter_param #(.WIDTH(4), .SATURATE(1), .RESET_VAL(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv4),
    .gray_count(b_gray), .bin_count_out(b_bin), .tc(b_tc), .sat(b_sat));
  gray_counter_param #(.WIDTH(8), .SATURATE(0), .RESET_VAL(10)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv8),
    .gray_count(c_gray), .bin_count_out(c_bin), .tc(c_tc), .sat(c_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; lv4 = 4'd9; lv8 = 8'd9;
    step(); step();
    chk("rst_a_bin", a_bin, 5);
    chk("rst_a_gray", a_gray, 4'b0111);
    chk("rst_a_tc", a_tc, 0);
    chk("rst_a_sat", a_sat, 0);
    chk("rst_c_bin", c_bin, 10);
    chk("rst_c_gray", c_gray, 8'h0F);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    step(); step(); step();
    chk("hold_a_bin", a_bin, 5);
    chk("hold_a_gray", a_gray, 4'b0111);
    // up-count wrap from 0
    load = 1'b1; lv4 = 4'd0;
    step();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    chk("ld0_a_gray", a_gray, 0);
    for (int i = 1; i <= 16; i++) begin
      prev = a_gray;
      step();
      chk($sformatf("up_gray[%0d]", i), a_gray, gray_seq[i]);
      chk($sformatf("up_tc[%0d]", i), a_tc, (i == 16) ? 1 : 0);
      chk($sformatf("up_hamming[%0d]", i), $countones(a_gray ^ prev), 1);
    end
    // down-count and reversal
    load = 1'b1; lv4 = 4'd2;
    step();
    load = 1'b0; up_dn = 1'b0;
    step(); chk("dn_bin1", a_bin, 1);  chk("dn_tc1", a_tc, 0);
    step(); chk("dn_bin0", a_bin, 0);  chk("dn_tc0", a_tc, 0);
    step(); chk("dn_bin15", a_bin, 15); chk("dn_tc15", a_tc, 1);
    chk("dn_gray15", a_gray, 4'h8);
    up_dn = 1'b1;
    step(); chk("rev_bin", a_bin, 0); chk("rev_tc", a_tc, 1);
    // saturation on the SATURATE=1 instance
    load = 1'b1; lv4 = 4'd14;
    step();
    load = 1'b0;
    step(); chk("sat_bin1", b_bin, 15); chk("sat_sat1", b_sat, 0);
    step(); chk("sat_bin2", b_bin, 15); chk("sat_sat2", b_sat, 1); chk("sat_tc2", b_tc, 0);
    step(); chk("sat_bin3", b_bin, 15); chk("sat_sat3", b_sat, 1); chk("sat_tc3", b_tc, 0);
    chk("sat_gray", b_gray, 4'h8);
    chk("wrap_nosat", a_sat, 0);
    up_dn = 1'b0;
    step(); chk("sat_dn_bin", b_bin, 14); chk("sat_dn_sat", b_sat, 0);
    // load has priority over counting
    load = 1'b1; lv4 = 4'd7;
    step();
    chk("ld7_bin", a_bin, 7);
    up_dn = 1'b1; lv4 = 4'd3;
    step();
    chk("ldpri_bin", a_bin, 3); chk("ldpri_gray", a_gray, 4'b0010); chk("ldpri_tc", a_tc, 0);
    lv4 = 4'd15;
    step();
    load = 1'b0;
    step(); chk("ld15_wrap_bin", a_bin, 0); chk("ld15_wrap_tc", a_tc, 1);
    // async reset mid-count on the 8-bit instance
    load = 1'b1; lv8 = 8'd200;
    step();
    load = 1'b0;
    step(); chk("c_bin201", c_bin, 201);
    #2 rst = 1'b0;
    #1;
    chk("async_c_bin", c_bin, 10);
    chk("async_c_gray", c_gray, 8'h0F);
    chk("async_a_bin", a_bin, 5);
    chk("async_a_tc", a_tc, 0);
    #1 rst = 1'b1;
    step();
    chk("post_rst_c_bin", c_bin, 11);
    chk("post_rst_a_bin", a_bin, 6);
    chk("post_rst_a_gray", a_gray, 4'b0101);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
